// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ID       = 4'd1,
    ST_ID_ACK   = 4'd2,
    ST_SUB      = 4'd3,
    ST_SUB_ACK  = 4'd4,
    ST_DATA     = 4'd5,
    ST_DATA_ACK = 4'd6,
    ST_RD       = 4'd7,
    ST_IGNORE   = 4'd8
  } sccb_state_e;

  localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
  localparam int         SCCB_BITS       = 8;
  localparam logic [3:0] SCCB_ACK_SLOT   = 4'd8;

endpackage

// File: rtl/sccb_line_sync.sv
// SIOC/SIOD synchronizer with registered rise/fall/start/stop strobes.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sioc_i,
  input  logic siod_i,
  output logic rise_o,
  output logic fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_now_s;
  logic                   sda_now_s;

  assign scl_now_s = scl_q[SYNC_STAGES-1];
  assign sda_now_s = sda_q[SYNC_STAGES-1];

  // Lines reset to the idle-high bus level so leaving reset creates no edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q      <= {SYNC_STAGES{1'b1}};
      sda_q      <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      sda_o      <= 1'b1;
    end else begin
      scl_q      <= {scl_q[SYNC_STAGES-2:0], sioc_i};
      sda_q      <= {sda_q[SYNC_STAGES-2:0], siod_i};
      scl_prev_q <= scl_now_s;
      sda_prev_q <= sda_now_s;
      rise_o     <= ~scl_prev_q & scl_now_s;
      fall_o     <= scl_prev_q & ~scl_now_s;
      start_o    <= scl_prev_q & scl_now_s & sda_prev_q & ~sda_now_s;
      stop_o     <= scl_prev_q & scl_now_s & ~sda_prev_q & sda_now_s;
      sda_o      <= sda_now_s;
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB camera-side responder: 3-phase write, 2-phase write + 2-phase read.
// Define SCCB_ACK_EN to drive the 9th-bit ACK slots low.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = SCCB_DEFAULT_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SIOC,
  input  logic       SIOD,
  output logic       SIOD_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy
);

  localparam logic [3:0] LAST_BIT = 4'(SCCB_BITS - 1);

  sccb_state_e state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  shift_q;
  logic        rd_q;
  logic        rise_s, fall_s, start_s, stop_s, sda_s;
  logic [7:0]  byte_d;
  logic [3:0]  cnt_d;
  logic        byte_done_s;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .sioc_i  (SIOC),
    .siod_i  (SIOD),
    .rise_o  (rise_s),
    .fall_o  (fall_s),
    .start_o (start_s),
    .stop_o  (stop_s),
    .sda_o   (sda_s)
  );

  assign byte_d      = {shift_q[6:0], sda_s};
  assign cnt_d       = cnt_q + 4'd1;
  assign byte_done_s = rise_s && (cnt_q == LAST_BIT);

  // Transaction FSM; stop beats start beats clock edges, in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      rd_q        <= 1'b0;
      SIOD_oe     <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wr_data <= 8'h00;
      reg_wr_en   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      if (stop_s) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        SIOD_oe <= 1'b0;
        busy    <= 1'b0;
      end else if (start_s) begin
        state_q <= ST_ID;
        cnt_q   <= 4'd0;
        SIOD_oe <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state_q)
          ST_ID, ST_SUB, ST_DATA: begin
            // Releases an ACK driven in the previous slot, on the fall that ends it.
            if (fall_s) SIOD_oe <= 1'b0;
            if (rise_s) begin
              shift_q <= byte_d;
              cnt_q   <= byte_done_s ? SCCB_ACK_SLOT : cnt_d;
            end
            if (byte_done_s) begin
              case (state_q)
                ST_ID: begin
                  if (byte_d == DEVICE_ID) begin
                    state_q <= ST_ID_ACK;
                    rd_q    <= 1'b0;
                  end else if (byte_d == (DEVICE_ID | 8'h01)) begin
                    state_q <= ST_ID_ACK;
                    rd_q    <= 1'b1;
                  end else begin
                    state_q <= ST_IGNORE;
                  end
                end
                ST_SUB: begin
                  reg_addr <= byte_d;
                  state_q  <= ST_SUB_ACK;
                end
                ST_DATA: begin
                  reg_wr_data <= byte_d;
                  reg_wr_en   <= 1'b1;
                  state_q     <= ST_DATA_ACK;
                end
                default: state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
`ifdef SCCB_ACK_EN
            if (fall_s) SIOD_oe <= 1'b1;
`endif
            if (rise_s) begin
              cnt_q <= 4'd0;
              case (state_q)
                ST_ID_ACK:  state_q <= rd_q ? ST_RD : ST_SUB;
                ST_SUB_ACK: state_q <= ST_DATA;
                default:    state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_RD: begin
            // Bits are driven on falls; the master samples on rises.
            if (fall_s) begin
              if (cnt_q == 4'd0) begin
                shift_q <= reg_rd_data;
                SIOD_oe <= ~reg_rd_data[7];
                cnt_q   <= cnt_d;
              end else if (cnt_q == SCCB_ACK_SLOT) begin
                SIOD_oe <= 1'b0;
                state_q <= ST_IGNORE;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                SIOD_oe <= ~shift_q[6];
                cnt_q   <= cnt_d;
              end
            end
          end
          ST_IDLE, ST_IGNORE: begin
            if (fall_s) SIOD_oe <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            SIOD_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed self-checking bench for sccb_responder acting as an SCCB master.
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 8;
`ifdef SCCB_ACK_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       SIOC;
  logic       sda_m;
  logic       SIOD;
  logic       SIOD_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic [7:0] reg_rd_data;
  logic       busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int         wr_cycles = 0;
  int         oe_cycles = 0;
  logic [7:0] wr_addr_cap = 8'h00;
  logic [7:0] wr_data_cap = 8'h00;

  int         wr_base;
  int         oe_base;
  int         ack_cnt;
  logic [7:0] oe_bits;
  logic       ack_oe;

  assign SIOD        = sda_m & ~SIOD_oe;
  assign reg_rd_data = (reg_addr == 8'h0A) ? 8'h76 : 8'h00;

  always #20 clk = ~clk;

  sccb_responder dut (
    .clk         (clk),
    .reset       (reset),
    .SIOC        (SIOC),
    .SIOD        (SIOD),
    .SIOD_oe     (SIOD_oe),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  always @(posedge clk) begin
    if (reg_wr_en) begin
      wr_cycles   <= wr_cycles + 1;
      wr_addr_cap <= reg_addr;
      wr_data_cap <= reg_wr_data;
    end
    if (SIOD_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; SIOC = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    SIOC = 1'b0;
  endtask

  task automatic rep_start();
    sda_m = 1'b1; wait_clk(Q);
    SIOC = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    SIOC = 1'b0;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    SIOC = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic bit_cycle(input logic b, output logic oe_hi);
    wait_clk(Q);
    sda_m = b; wait_clk(Q);
    SIOC = 1'b1; wait_clk(Q);
    oe_hi = SIOD_oe; wait_clk(Q);
    SIOC = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] oe_v, output logic ack);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(b[i], o);
      oe_v[i] = o;
    end
    bit_cycle(1'b1, ack);
  endtask

  initial begin
    reset = 1'b1; SIOC = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    chk("rst_oe",    32'(SIOD_oe), 32'(1'b0));
    chk("rst_addr",  32'(reg_addr), 32'(8'h00));
    chk("rst_wdata", 32'(reg_wr_data), 32'(8'h00));
    chk("rst_wen",   32'(reg_wr_en), 32'(1'b0));
    chk("rst_busy",  32'(busy), 32'(1'b0));
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    wait_clk(4);

    // 3-phase write 0x42, 0x12, 0x80
    wr_base = wr_cycles;
    bus_start();
    chk("t1_busy_start", 32'(busy), 32'(1'b1));
    send_byte(8'h42, oe_bits, ack_oe);
    chk("t1_ack_id", 32'(ack_oe), 32'(ACK_EXP));
    chk("t1_oe_id", 32'(oe_bits), 32'(8'h00));
    send_byte(8'h12, oe_bits, ack_oe);
    chk("t1_ack_sub", 32'(ack_oe), 32'(ACK_EXP));
    send_byte(8'h80, oe_bits, ack_oe);
    chk("t1_ack_data", 32'(ack_oe), 32'(ACK_EXP));
    chk("t1_state_ign", 32'(dut.state_q), 32'(ST_IGNORE));
    chk("t1_busy_pre", 32'(busy), 32'(1'b1));
    bus_stop();
    chk("t1_wr_count", 32'(wr_cycles - wr_base), 32'd1);
    chk("t1_wr_addr", 32'(wr_addr_cap), 32'(8'h12));
    chk("t1_wr_data", 32'(wr_data_cap), 32'(8'h80));
    chk("t1_busy_stop", 32'(busy), 32'(1'b0));
    chk("t1_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Wrong ID 0x60: never driven, never written
    wr_base = wr_cycles; oe_base = oe_cycles;
    bus_start();
    send_byte(8'h60, oe_bits, ack_oe);
    send_byte(8'h12, oe_bits, ack_oe);
    send_byte(8'h80, oe_bits, ack_oe);
    chk("t2_state_ign", 32'(dut.state_q), 32'(ST_IGNORE));
    bus_stop();
    chk("t2_wr_count", 32'(wr_cycles - wr_base), 32'd0);
    chk("t2_oe_cycles", 32'(oe_cycles - oe_base), 32'd0);
    chk("t2_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t2_addr_kept", 32'(reg_addr), 32'(8'h12));

    // 2-phase write of 0x0A, then 2-phase read returning 0x76
    wr_base = wr_cycles;
    bus_start();
    send_byte(8'h42, oe_bits, ack_oe);
    send_byte(8'h0A, oe_bits, ack_oe);
    bus_stop();
    chk("t3_addr", 32'(reg_addr), 32'(8'h0A));
    bus_start();
    send_byte(8'h43, oe_bits, ack_oe);
    chk("t3_ack_rid", 32'(ack_oe), 32'(ACK_EXP));
    send_byte(8'hFF, oe_bits, ack_oe);
    chk("t3_rd_bits", 32'(oe_bits), 32'(8'h89));
    chk("t3_na_released", 32'(ack_oe), 32'(1'b0));
    chk("t3_state_ign", 32'(dut.state_q), 32'(ST_IGNORE));
    bus_stop();
    chk("t3_wr_count", 32'(wr_cycles - wr_base), 32'd0);

    // Stop after 5 data bits of 0x42, 0x20 write
    wr_base = wr_cycles;
    bus_start();
    send_byte(8'h42, oe_bits, ack_oe);
    send_byte(8'h20, oe_bits, ack_oe);
    for (int i = 0; i < 5; i++) bit_cycle(1'b1, ack_oe);
    bus_stop();
    chk("t4_wr_count", 32'(wr_cycles - wr_base), 32'd0);
    chk("t4_addr_kept", 32'(reg_addr), 32'(8'h20));
    chk("t4_busy", 32'(busy), 32'(1'b0));

    // Reset mid-read while driving bit 7 of 0x00 (oe=1)
    bus_start();
    send_byte(8'h43, oe_bits, ack_oe);
    wait_clk(Q);
    chk("t5_oe_driving", 32'(SIOD_oe), 32'(1'b1));
    reset = 1'b1;
    #1;
    chk("t5_oe_async", 32'(SIOD_oe), 32'(1'b0));
    SIOC = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    chk("t5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t5_busy", 32'(busy), 32'(1'b0));
    chk("t5_addr_rst", 32'(reg_addr), 32'(8'h00));

    // Repeated start mid-DATA, then a full 0x42, 0x3A, 0x04 write
    wr_base = wr_cycles;
    bus_start();
    send_byte(8'h42, oe_bits, ack_oe);
    send_byte(8'h3A, oe_bits, ack_oe);
    for (int i = 0; i < 3; i++) bit_cycle(1'b0, ack_oe);
    rep_start();
    wait_clk(Q);
    chk("t6_state_id", 32'(dut.state_q), 32'(ST_ID));
    chk("t6_no_wr_yet", 32'(wr_cycles - wr_base), 32'd0);
    oe_base = oe_cycles;
    ack_cnt = 0;
    send_byte(8'h42, oe_bits, ack_oe);
    ack_cnt += int'(ack_oe);
    send_byte(8'h3A, oe_bits, ack_oe);
    ack_cnt += int'(ack_oe);
    send_byte(8'h04, oe_bits, ack_oe);
    ack_cnt += int'(ack_oe);
    bus_stop();
    chk("t6_ack_slots", 32'(ack_cnt), ACK_EXP ? 32'd3 : 32'd0);
    chk("t6_wr_count", 32'(wr_cycles - wr_base), 32'd1);
    chk("t6_wr_addr", 32'(wr_addr_cap), 32'(8'h3A));
    chk("t6_wr_data", 32'(wr_data_cap), 32'(8'h04));
    if (!ACK_EXP) chk("t6_oe_quiet", 32'(oe_cycles - oe_base), 32'd0);
    else chk("t6_oe_some", 32'(oe_cycles - oe_base > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
